// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared ALU and the response consumer.
// The master side is the environment (requesters, ALU, consumer); the slave side is alu_arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_ctrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_ctrl;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a held response buffer.
// Optional build macro ALU_ARB_STATS_EN adds saturating accept/stall counters.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  stat_cnt0,
  output logic [15:0]  stat_cnt1,
  output logic [15:0]  stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_ctrl;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic             w_grant_id;
  logic             w_issue;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  // On a tie the requester that did not win last time goes first.
  assign w_grant_id = (&w_valid) ? ~r_last_grant : w_valid[1];
  assign w_issue    = (r_state == IDLE) && (|w_valid);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = w_issue && (w_grant_id == gi[0]);
    end
  endgenerate

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_ctrl   = r_alu_ctrl;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= 4'b0000;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_alu_a      <= w_grant_id ? bus.req1_a    : bus.req0_a;
            r_alu_b      <= w_grant_id ? bus.req1_b    : bus.req0_b;
            r_alu_ctrl   <= w_grant_id ? bus.req1_ctrl : bus.req0_ctrl;
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_zero   <= bus.alu_zero;
          r_rsp_id     <= r_owner;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [2:0]  w_stat_inc;
  logic [15:0] r_stat [3];

  assign w_stat_inc[0] = w_valid[0] && w_ready[0];
  assign w_stat_inc[1] = w_valid[1] && w_ready[1];
  assign w_stat_inc[2] = (w_valid[0] && !w_ready[0]) || (w_valid[1] && !w_ready[1]);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_stat[gi] <= 16'h0000;
        end else if (w_stat_inc[gi] && (r_stat[gi] != 16'hFFFF)) begin
          r_stat[gi] <= r_stat[gi] + 16'h0001;
        end
      end
    end
  endgenerate

  assign stat_cnt0  = r_stat[0];
  assign stat_cnt1  = r_stat[1];
  assign stat_stall = r_stat[2];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_stall;
`endif

  alu_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_stall (stat_stall)
`endif
  );

  // Reference ALU, also used to play the external ALU
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  assign bus.alu_zero   = (alu_ref(bus.alu_a, bus.alu_b, bus.alu_ctrl) == '0);

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_on = 0;
  bit          m_busy;
  bit          m_last;
  bit          m_id;
  int          m_acc;
  logic [W-1:0] m_res;
  bit          m_zero;
  logic [W-1:0] m_a, m_b;
  logic [3:0]  m_c;
  int          k = 0;
  int          m_cnt0, m_cnt1, m_stall;
  int          dut_grants[$];

  always @(negedge clk) begin
    bit e0, e1, erv;
    if (!rst_n) begin
      m_on = 1; m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_c = '0;
      m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
    end else if (m_on) begin
      e0  = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
      e1  = !m_busy && bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
      erv = m_busy && (k >= m_acc + 2);
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("rsp_valid", bus.rsp_valid, erv);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_ctrl", bus.alu_ctrl, m_c);
      if (erv) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_zero", bus.rsp_zero, m_zero);
      end
`ifdef ALU_ARB_STATS_EN
      chk("stat_cnt0", stat_cnt0, m_cnt0);
      chk("stat_cnt1", stat_cnt1, m_cnt1);
      chk("stat_stall", stat_stall, m_stall);
      if ((bus.req0_valid && !e0) || (bus.req1_valid && !e1))
        if (m_stall < 65535) m_stall++;
      if (e0 && m_cnt0 < 65535) m_cnt0++;
      if (e1 && m_cnt1 < 65535) m_cnt1++;
`endif
      if (bus.req0_valid && bus.req0_ready) dut_grants.push_back(0);
      if (bus.req1_valid && bus.req1_ready) dut_grants.push_back(1);
      if (erv && bus.rsp_ready) begin
        $display("txn: id=%0d result=%08h zero=%0d", m_id, m_res, m_zero);
        m_busy = 0;
      end
      if (e0 || e1) begin
        m_busy = 1; m_acc = k; m_id = e1;
        m_a = e1 ? bus.req1_a : bus.req0_a;
        m_b = e1 ? bus.req1_b : bus.req0_b;
        m_c = e1 ? bus.req1_ctrl : bus.req0_ctrl;
        m_res = alu_ref(m_a, m_b, m_c);
        m_zero = (m_res == '0);
        m_last = e1;
      end
    end
    k++;
  end

  // ---------------- stimulus helpers ----------------
  logic [3:0] ctrl_tab [6];
  initial begin
    ctrl_tab[0] = 4'b0000; ctrl_tab[1] = 4'b0001; ctrl_tab[2] = 4'b0010;
    ctrl_tab[3] = 4'b0110; ctrl_tab[4] = 4'b0111; ctrl_tab[5] = 4'b1100;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_op0();
    bus.req0_a = ($urandom % 2) ? $urandom : $urandom_range(0, 7);
    bus.req0_b = ($urandom % 2) ? $urandom : $urandom_range(0, 7);
    bus.req0_ctrl = ctrl_tab[$urandom_range(0, 5)];
  endtask

  task automatic rand_op1();
    bus.req1_a = ($urandom % 2) ? $urandom : $urandom_range(0, 7);
    bus.req1_b = ($urandom % 2) ? $urandom : $urandom_range(0, 7);
    bus.req1_ctrl = ctrl_tab[$urandom_range(0, 5)];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (5) tick();
  endtask

  // Wait (bounded) for the given requester's ready; returns after the handshake edge.
  task automatic wait_hs(input int n, input string name);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? bus.req0_ready : bus.req1_ready;
      tick();
    end
    chk(name, got, 1'b1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) break;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit r0, r1;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp_ready = 0;

    // Reset values
    do_reset();
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);

    // Single op: 5 + 3
    bus.rsp_ready = 1;
    bus.req0_a = 5; bus.req0_b = 3; bus.req0_ctrl = 4'b0010; bus.req0_valid = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req0_ready) break;
    end
    chk("t1_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    wait_rsp(n);
    chk("t1_latency", n, 2);
    chk("t1_result", bus.rsp_result, 8);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_zero", bus.rsp_zero, 0);
    drain();

    // Contention from reset: strict alternation starting with req0
    do_reset();
    bus.rsp_ready = 1;
    dut_grants.delete();
    rand_op0(); rand_op1();
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 80 && dut_grants.size() < 6; i++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      tick();
      if (r0) rand_op0();
      if (r1) rand_op1();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    chk("t2_count", (dut_grants.size() >= 6), 1);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      chk($sformatf("t2_grant%0d", i), dut_grants[i], i % 2);
    drain();

    // Back-pressure with a zero result (7 - 7); last grant was req1 so req0 wins
    bus.rsp_ready = 0;
    bus.req0_a = 7; bus.req0_b = 7; bus.req0_ctrl = 4'b0110; bus.req0_valid = 1;
    rand_op1(); bus.req1_valid = 1;
    wait_hs(0, "t3_hs");
    rand_op0();
    wait_rsp(n);
    chk("t3_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_valid", bus.rsp_valid, 1);
      chk("t3_hold_result", bus.rsp_result, 0);
      chk("t3_hold_zero", bus.rsp_zero, 1);
      chk("t3_ready0_low", bus.req0_ready, 0);
      chk("t3_ready1_low", bus.req1_ready, 0);
    end
    tick();
    bus.rsp_ready = 1;
    @(negedge clk);
    chk("t3_still_valid", bus.rsp_valid, 1);
    @(negedge clk);
    chk("t3_consumed", bus.rsp_valid, 0);
    chk("t3_next_grant1", bus.req1_ready, 1);
    tick();
    drain();

    // Lone requester 1
    for (int j = 0; j < 4; j++) begin
      rand_op1(); bus.req1_valid = 1;
      wait_hs(1, "t4_hs");
      bus.req1_valid = 0;
      wait_rsp(n);
      chk("t4_rsp_id", bus.rsp_id, 1);
      tick();
    end
    drain();

    // Reset while the op is in EXEC
    bus.req0_a = 32'h10; bus.req0_b = 32'h20; bus.req0_ctrl = 4'b0001; bus.req0_valid = 1;
    wait_hs(0, "t5_hs");
    bus.req0_valid = 0;
    rst_n = 0;
    tick();
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_alu_ctrl", bus.alu_ctrl, 0);
    chk("t5_alu_a", bus.alu_a, 0);
    rst_n = 1;
    bus.req0_a = 3; bus.req0_b = 9; bus.req0_ctrl = 4'b0111; bus.req0_valid = 1;
    @(negedge clk);
    chk("t5_idle_ready0", bus.req0_ready, 1);
    chk("t5_no_rsp", bus.rsp_valid, 0);
    tick();
    bus.req0_valid = 0;
    drain();

    // Randomized traffic with early withdrawals and random back-pressure
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      tick();
      if (bus.req0_valid && r0) begin bus.req0_valid = ($urandom % 4) != 0; rand_op0(); end
      else if (bus.req0_valid && ($urandom % 16) == 0) bus.req0_valid = 0;
      else if (!bus.req0_valid && ($urandom % 3) == 0) begin bus.req0_valid = 1; rand_op0(); end
      if (bus.req1_valid && r1) begin bus.req1_valid = ($urandom % 4) != 0; rand_op1(); end
      else if (bus.req1_valid && ($urandom % 16) == 0) bus.req1_valid = 0;
      else if (!bus.req1_valid && ($urandom % 3) == 0) begin bus.req1_valid = 1; rand_op1(); end
      bus.rsp_ready = ($urandom % 3) != 0;
    end
    drain();

`ifdef ALU_ARB_STATS_EN
    // Counters: 3 req0 + 2 req1 under contention, then stall saturation
    do_reset();
    bus.rsp_ready = 1;
    dut_grants.delete();
    rand_op0(); rand_op1();
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 80 && dut_grants.size() < 5; i++) begin
      @(negedge clk);
      r0 = bus.req0_ready; r1 = bus.req1_ready;
      tick();
      if (r0) rand_op0();
      if (r1) rand_op1();
      if (dut_grants.size() >= 5) begin bus.req0_valid = 0; bus.req1_valid = 0; end
    end
    drain();
    chk("st_cnt0", stat_cnt0, 3);
    chk("st_cnt1", stat_cnt1, 2);
    bus.rsp_ready = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (65600) tick();
    chk("st_stall_sat", stat_stall, 16'hFFFF);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
